// File: rtl/logit_argmax.sv
// Scans the Layer 2 logit buffer after it reports done and publishes the argmax class.
// Define LOGIT_ARGMAX_MARGIN_EN to add runner-up tracking and a top-minus-second margin output.
module logit_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int LOGIT_W     = 6,
  parameter int IDX_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [IDX_W-1:0]          logit_addr,
  input  logic signed [LOGIT_W-1:0] logit_data,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          class_out,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic [LOGIT_W:0]          margin
);

  // Handshake: start is a level request that stays high until done is seen.
  // done stays high until start falls. A new scan needs start to fall and rise again.

  typedef enum logic [1:0] {IDLE, SCAN, DONE_ST} state_t;

  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [LOGIT_W-1:0] MOST_NEG = {1'b1, {(LOGIT_W-1){1'b0}}};

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            best_idx;
  logic signed [LOGIT_W-1:0]   best;

`ifdef LOGIT_ARGMAX_MARGIN_EN
  logic signed [LOGIT_W-1:0]   second;
  logic [LOGIT_W:0]            margin_diff;

  // One extra bit keeps best-second from wrapping when best is max and second is min.
  assign margin_diff = {best[LOGIT_W-1], best} - {second[LOGIT_W-1], second};
`else
  assign margin = '0;
`endif

  assign logit_addr = (state == SCAN) ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      class_out <= '0;
      max_logit <= '0;
`ifdef LOGIT_ARGMAX_MARGIN_EN
      second    <= '0;
      margin    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end

        SCAN: begin
          if (idx == '0) begin
            best     <= logit_data;
            best_idx <= '0;
`ifdef LOGIT_ARGMAX_MARGIN_EN
            second   <= MOST_NEG;
`endif
          end else if (logit_data > best) begin
            // Strict compare: equal values keep the earlier (lower) index.
`ifdef LOGIT_ARGMAX_MARGIN_EN
            second   <= best;
`endif
            best     <= logit_data;
            best_idx <= idx;
          end
`ifdef LOGIT_ARGMAX_MARGIN_EN
          else if (logit_data > second) begin
            second <= logit_data;
          end
`endif
          if (idx == LAST_IDX) begin
            state <= DONE_ST;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE_ST: begin
          if (!done) begin
            class_out <= best_idx;
            max_logit <= best;
`ifdef LOGIT_ARGMAX_MARGIN_EN
            margin    <= margin_diff;
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
          end else if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax: a logit memory model feeds the read port and
// every scan result is checked against hand-computed class/max/margin values.
module tb_logit_argmax;

  localparam int NC = 10;
  localparam int LW = 6;
  localparam int IW = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [IW-1:0]        logit_addr;
  logic signed [LW-1:0] logit_data;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        class_out;
  logic signed [LW-1:0] max_logit;
  logic [LW:0]          margin;

  logic signed [LW-1:0] mem [0:NC-1];

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  logit_argmax #(.NUM_CLASSES(NC), .LOGIT_W(LW), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .logit_addr (logit_addr),
    .logit_data (logit_data),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .max_logit  (max_logit),
    .margin     (margin)
  );

  // Layer 2 buffer model: combinational read, X outside the valid range.
  assign logit_data = (int'(logit_addr) < NC) ? mem[logit_addr] : 'x;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_margin(input int raw);
`ifdef LOGIT_ARGMAX_MARGIN_EN
    return 32'(raw);
`else
    return 32'(raw * 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v[NC]);
    for (int i = 0; i < NC; i++) mem[i] = v[i][LW-1:0];
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_class"},  32'(class_out), 32'(e[31:16]));
    check({tag, "_max"},    32'(max_logit), {{26{e[15]}}, e[15:10]});
    check({tag, "_margin"}, 32'(margin),    32'(e[9:0]));
    check({tag, "_busy"},   32'(busy),      32'd0);
  endtask

  // Runs one scan from IDLE with start raised at #1 after an edge.
  task automatic do_scan(input string tag, input int e_class, input int e_max,
                         input int e_margin, input int prev_class);
    int cycles;
    exp_q.push_back({16'(e_class), 6'(e_max), 10'(exp_margin(e_margin))});
    start = 1'b1;
    tick(); tick(); tick();
    check({tag, "_busy_mid"},  32'(busy),      32'd1);
    check({tag, "_hold_mid"},  32'(class_out), 32'(prev_class));
    check({tag, "_addr_mid"},  32'(logit_addr), 32'd2);
    begin
      int more;
      wait_done(more);
      cycles = 3 + more;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd12);
    check_result(tag);
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cycles;
    logic ok_done, ok_busy, ok_addr;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NC; i++) mem[i] = '0;
    tick(); tick();
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_class",  32'(class_out),  32'd0);
    check("rst_max",    32'(max_logit),  32'd0);
    check("rst_margin", 32'(margin),     32'd0);
    check("rst_addr",   32'(logit_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Tie between indices 1 and 2 keeps the lower one
    load('{-32, -5, -5, -32, -32, -32, -32, -32, -32, -32});
    do_scan("tie", 1, -5, 0, 0);
    drop_start("tie");

    load('{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32});
    do_scan("allneg", 0, -32, 0, 1);
    drop_start("allneg");

    // Max-to-min margin needs the extra bit
    load('{31, -32, -32, -32, -32, -32, -32, -32, -32, -32});
    do_scan("wide", 0, 31, 63, 0);
    drop_start("wide");

    load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    do_scan("ramp", 9, 9, 1, 0);
    drop_start("ramp");
    check("ramp_retain_idle", 32'(class_out), 32'd9);

    // Asynchronous reset at scan index 4, start kept high across it
    load('{3, -7, 12, -1, 20, 4, 20, -30, 0, 19});
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("abort_addr_pre", 32'(logit_addr), 32'd4);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_done",  32'(done),       32'd0);
    check("abort_class", 32'(class_out),  32'd0);
    check("abort_addr",  32'(logit_addr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    exp_q.push_back({16'd4, 6'(20), 10'(exp_margin(0))});
    wait_done(cycles);
    check("abort_rescan_latency", 32'(cycles), 32'd12);
    check_result("abort_rescan");

    // Held start must not retrigger
    ok_done = 1'b1;
    ok_busy = 1'b1;
    ok_addr = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 1'b1) ok_done = 1'b0;
      if (busy !== 1'b0) ok_busy = 1'b0;
      if (logit_addr !== '0) ok_addr = 1'b0;
    end
    check("held_done", 32'(ok_done), 32'd1);
    check("held_busy", 32'(ok_busy), 32'd1);
    check("held_addr", 32'(ok_addr), 32'd1);
    check("held_class", 32'(class_out), 32'd4);

    load('{5, 0, 0, 0, 0, 0, 0, 0, 0, -3});
    drop_start("reuse");
    do_scan("reuse", 0, 5, 5, 4);
    drop_start("reuse_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logit_argmax.md
Name: logit_argmax

Overview:
- Downstream consumer of the Layer 2 logit buffer.
- After Layer 2 asserts done, it walks the NUM_CLASSES signed logits through Layer 2's combinational read port (read_addr / read_data).
- It reports the winning class index and a validity flag to the top-level output pins.
- Optional: a confidence margin (top logit minus runner-up).

Parameters:
- NUM_CLASSES, 10: number of logits scanned (must be >= 2 and <= 2**IDX_W).
- LOGIT_W, 6: signed logit width.
- IDX_W, 4: width of address and class index.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request, driven from Layer 2 done; held high until this block's done is seen.
- logit_addr  output  IDX_W  drives Layer 2 read_addr.
- logit_data  input  LOGIT_W  signed; Layer 2 read_data, combinational from logit_addr.
- busy  output  1  scan in progress.
- done  output  1  result valid; held until start falls.
- class_out  output  IDX_W  index of the maximum logit.
- max_logit  output  LOGIT_W  signed value of the maximum logit.
- margin  output  LOGIT_W+1  unsigned max minus second-max (only with the optional feature).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, class_out=0, max_logit=0, logit_addr=0, margin=0.
  - Internal best and second-best registers cleared.
  - A reset mid-scan aborts the scan; the next scan starts only on a fresh start after reset release.
- States: IDLE, SCAN, DONE_ST.
- IDLE:
  - done=0, busy=0, logit_addr=0.
  - On start=1: go to SCAN, busy<=1, index counter<=0.
- SCAN (exactly NUM_CLASSES cycles, one per index k=0..NUM_CLASSES-1):
  - logit_addr=k, driven combinationally from the counter.
  - logit_data is sampled in the same cycle.
  - At k=0: best<=logit_data, best_idx<=0, second<=most-negative value (-2**(LOGIT_W-1)).
  - At k>0, comparisons are signed:
    - If logit_data > best (strict): second<=best, best<=logit_data, best_idx<=k.
    - Else if logit_data > second: second<=logit_data.
  - Ties keep the lower index.
  - At k=NUM_CLASSES-1: the update is applied, then the state goes to DONE_ST.
  - start is ignored in SCAN; a drop of start mid-scan does not abort it.
- DONE_ST entry (registered):
  - class_out<=best_idx, max_logit<=best, margin<=best-second computed at LOGIT_W+1 bits (no overflow; range 0..2**LOGIT_W-1).
  - done<=1, busy<=0.
  - Remain in DONE_ST while start=1.
  - On start=0: go to IDLE, done<=0.
- Latency:
  - start sampled high in IDLE at edge N.
  - SCAN occupies edges N+1..N+NUM_CLASSES.
  - done=1 and outputs valid after edge N+NUM_CLASSES+1 (12 cycles at default).
- Output retention:
  - class_out, max_logit and margin hold their last value through IDLE until the next scan completes.
  - They are never updated mid-scan.
- Reuse: start must fall and rise again for a new scan; a continuously high start yields exactly one scan.
- logit_addr never exceeds NUM_CLASSES-1.

Optional Feature:
- Macro LOGIT_ARGMAX_MARGIN_EN.
- Defined: the second-best tracking and margin port are present, behaving as above.
- Undefined:
  - The second-best register and comparator are removed.
  - The margin port is still present but tied to 0.
  - All other timing is identical.

Test Plan:
- Logits [0,1,2,3,4,5,6,7,8,9] -> class_out=9, max_logit=9, margin=1; done rises 12 cycles after start.
- Logits [-32,-5,-5,-32,...,-32] -> class_out=1 (tie keeps the lower index), max_logit=-5, margin=0.
- All logits = -32 -> class_out=0, max_logit=-32, margin=0.
- Logits with 31 at index 0 and -32 elsewhere -> class_out=0, margin=63 (7-bit, no wrap); without the macro, margin=0.
- rst_n pulsed low at SCAN index 4 -> busy=0, done=0 and class_out=0 immediately (asynchronous); holding start high after release triggers a full fresh 10-cycle scan with the correct result.
- start held high 30 cycles after done -> only one scan occurs and logit_addr stays 0. Then start low for 1 cycle and high again with new logits [5,0,0,0,0,0,0,0,0,-3] -> done drops, rises again with class_out=0, margin=5.
